sdp_ram_responder: RTL and testbench
====================================

Name: sdp_ram_responder

Overview:
- Synthesizable behavioural simple-dual-port RAM: one write port, one read port, single clock.
- Answers the write/read traffic of the SDP BRAM formal harness and serves as the "gold" side of the gold/gate miter.
- Adds per-address written-tracking so the harness can qualify read data without a free-running written flag.
- Sits in the QL BRAM formal test area and maps to distributed/BRAM inference when synthesized.

Parameters:
- ABITS, 10, address width; depth = 2**ABITS.
- DBITS, 36, data width.
- READ_LATENCY, 1, ra-to-rd latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable.
- wa  input  ABITS  write address.
- wd  input  DBITS  write data.
- re  input  1  read enable; rd holds its value when re=0.
- ra  input  ABITS  read address.
- rd  output  DBITS  read data.
- rd_valid  output  1  rd comes from an address written since reset.

Behaviour:
- Reset (async assert, sync deassert expected externally):
  - rd=0, rd_valid=0.
  - All per-address written bits cleared.
  - Read pipeline stages cleared.
  - Memory array contents NOT reset; they are undefined/retained.
- Write: at posedge with we=1, mem[wa]<=wd and written[wa]<=1. Writes are ignored while rst_n=0.
- Read, READ_LATENCY=1:
  - At posedge with re=1: rd<=mem[ra] and rd_valid<=written[ra], both sampled pre-write.
  - re=0: rd and rd_valid hold.
- Read, READ_LATENCY=2:
  - Stage 1 captures mem[ra], written[ra] and re.
  - Stage 2 loads rd/rd_valid only when the stage-1 captured re=1, else holds.
  - Back-to-back reads every cycle are sustained; no stalls.
- Read-during-write, same address, same cycle (we=1, re=1, wa==ra): read-first. rd gets the old mem contents and rd_valid the old written bit. Overridden by the optional feature below.
- Different addresses: fully independent.
- Address wrap: none; addresses are exactly ABITS wide, every value is legal.
- Reset mid-read: pipeline flushed; a read in flight is discarded; rd_valid=0 on the first cycle after deassertion.
- Reset mid-write: the in-flight write is dropped.
- READ_LATENCY outside {1,2}: elaboration-time $error.

Optional Feature:
- Macro: SDP_RAM_WRITE_FIRST_EN.
- Defined: same-address read-during-write is write-first. rd gets wd and rd_valid=1, via a bypass mux at stage 1 (ra==wa && we && re).
- Undefined: read-first as above; no bypass logic instantiated.
- The miter harness selects the variant to match the gate netlist's configured BRAM mode.

Decomposition:
- Package sdp_ram_pkg holds:
  - default ABITS/DBITS (sourced from params.vh values);
  - localparam DEPTH function;
  - typedef addr_t and data_t;
  - enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST} for reporting mode in assertions.
- One sub-module, sdp_written_tracker: DEPTH-bit flop vector with async clear, set port (we,wa) and lookup port (ra) returning the written bit. Kept separate so the tracker can be swapped for a formal-only rand-address single-bit variant.

Test Plan:
- Reset then read ra=5, re=1, READ_LATENCY=1 -> next cycle rd_valid=0 (rd value don't-care).
- Write wa=3 wd=0xABC, next cycle read ra=3 -> one cycle later rd=0xABC, rd_valid=1. With READ_LATENCY=2 the same response arrives two cycles after ra.
- Write wa=7 wd=0x11; later same cycle we=1 wa=7 wd=0x22 with re=1 ra=7 -> default rd=0x11; with SDP_RAM_WRITE_FIRST_EN rd=0x22. Both cases rd_valid=1.
- Write addr 0 and addr 2**ABITS-1 with distinct data, read both back-to-back -> correct data on consecutive cycles, no aliasing.
- Read ra=3 (written), then re=0 for 3 cycles with ra changing -> rd/rd_valid held at the addr-3 values.
- Write addr 4, pulse rst_n low mid-stream while a read of addr 4 is in flight (READ_LATENCY=2) -> rd=0, rd_valid=0 after reset. A subsequent read of addr 4 gives rd_valid=0 until it is rewritten.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared types and sizing helpers for the simple-dual-port RAM responder.
// SDP_RAM_WRITE_FIRST_EN selects the same-address read-during-write mode reported by RDW_MODE.
package sdp_ram_pkg;

  localparam int DEFAULT_ABITS = 10;
  localparam int DEFAULT_DBITS = 36;

  typedef logic [DEFAULT_ABITS-1:0] addr_t;
  typedef logic [DEFAULT_DBITS-1:0] data_t;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

`ifdef SDP_RAM_WRITE_FIRST_EN
  localparam rdw_mode_e RDW_MODE = RDW_WRITE_FIRST;
`else
  localparam rdw_mode_e RDW_MODE = RDW_READ_FIRST;
`endif

  function automatic int depth_of(input int abits);
    return 1 << abits;
  endfunction

endpackage

// File: rtl/sdp_written_tracker.sv
// One flag per address, set on write and cleared only by reset; the lookup port
// reports whether an address has been written since reset.
module sdp_written_tracker
  import sdp_ram_pkg::*;
#(
  parameter int ABITS = DEFAULT_ABITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [ABITS-1:0] set_addr,
  input  logic [ABITS-1:0] lookup_addr,
  output logic             written
);

  localparam int DEPTH = depth_of(ABITS);

  logic [DEPTH-1:0] written_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          written_reg[gi] <= 1'b0;
        end else if (set_en && (set_addr == ABITS'(gi))) begin
          written_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign written = written_reg[lookup_addr];

endmodule

// File: rtl/sdp_ram_responder.sv
// Behavioural simple-dual-port RAM with per-address written tracking and 1 or 2 cycle read latency.
// Define SDP_RAM_WRITE_FIRST_EN for write-first same-address read-during-write; default is read-first.
module sdp_ram_responder
  import sdp_ram_pkg::*;
#(
  parameter int ABITS        = DEFAULT_ABITS,
  parameter int DBITS        = DEFAULT_DBITS,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ABITS-1:0] wa,
  input  logic [DBITS-1:0] wd,
  input  logic             re,
  input  logic [ABITS-1:0] ra,
  output logic [DBITS-1:0] rd,
  output logic             rd_valid
);

  localparam int DEPTH = depth_of(ABITS);

  logic [DBITS-1:0] mem [DEPTH];
  logic             written_rd;
  logic [DBITS-1:0] s1_data_next;
  logic             s1_valid_next;
  logic [DBITS-1:0] rd_reg;
  logic             rd_valid_reg;

  // Contents are never cleared; the empty reset branch only blocks writes while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  sdp_written_tracker #(
    .ABITS(ABITS)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (we),
    .set_addr   (wa),
    .lookup_addr(ra),
    .written    (written_rd)
  );

`ifdef SDP_RAM_WRITE_FIRST_EN
  logic bypass;
  assign bypass        = we && re && (wa == ra);
  assign s1_data_next  = bypass ? wd : mem[ra];
  assign s1_valid_next = bypass | written_rd;
`else
  assign s1_data_next  = mem[ra];
  assign s1_valid_next = written_rd;
`endif

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_reg       <= '0;
          rd_valid_reg <= 1'b0;
        end else if (re) begin
          rd_reg       <= s1_data_next;
          rd_valid_reg <= s1_valid_next;
        end
      end
    end else if (READ_LATENCY == 2) begin : g_lat2
      logic [DBITS-1:0] s1_data_reg;
      logic             s1_valid_reg;
      logic             s1_re_reg;

      // Stage 1 captures every cycle; stage 2 only advances for captured reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_data_reg  <= '0;
          s1_valid_reg <= 1'b0;
          s1_re_reg    <= 1'b0;
          rd_reg       <= '0;
          rd_valid_reg <= 1'b0;
        end else begin
          s1_data_reg  <= s1_data_next;
          s1_valid_reg <= s1_valid_next;
          s1_re_reg    <= re;
          if (s1_re_reg) begin
            rd_reg       <= s1_data_reg;
            rd_valid_reg <= s1_valid_reg;
          end
        end
      end
    end else begin : g_bad_latency
      $error("sdp_ram_responder: READ_LATENCY must be 1 or 2");
      assign rd_reg       = '0;
      assign rd_valid_reg = 1'b0;
    end
  endgenerate

  assign rd       = rd_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_sdp_ram_responder.sv
// Drives latency-1 and latency-2 responders with identical traffic and checks both against
// an address-indexed reference memory with a read-response delay line.
module tb_sdp_ram_responder;

  localparam int AW    = 4;
  localparam int DW    = 36;
  localparam int DEPTH = 1 << AW;
`ifdef SDP_RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic          re = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] rd1, rd2;
  logic          rdv1, rdv2;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DW-1:0] mem_m [DEPTH];
  bit            wr_m  [DEPTH];
  logic [DW-1:0] exp1_d, exp2_d, pend_d;
  bit            exp1_v, exp2_v, pend_v, pend_re;

  always #5 clk = ~clk;

  sdp_ram_responder #(.ABITS(AW), .DBITS(DW), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd1), .rd_valid(rdv1)
  );

  sdp_ram_responder #(.ABITS(AW), .DBITS(DW), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd2), .rd_valid(rdv2)
  );

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) wr_m[i] = 1'b0;
    exp1_d = '0; exp1_v = 1'b0;
    exp2_d = '0; exp2_v = 1'b0;
    pend_d = '0; pend_v = 1'b0; pend_re = 1'b0;
  endtask

  // One clock of traffic; the model answers with read-first (or write-first) semantics.
  task automatic step(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit r, input logic [AW-1:0] b);
    bit            byp;
    logic [DW-1:0] rdat;
    bit            rv;
    @(negedge clk);
    we = w; wa = a; wd = d; re = r; ra = b;
    @(posedge clk);
    byp  = WF && w && r && (a == b);
    rdat = byp ? d : mem_m[b];
    rv   = byp ? 1'b1 : wr_m[b];
    if (pend_re) begin
      exp2_d = pend_d;
      exp2_v = pend_v;
    end
    pend_re = r; pend_d = rdat; pend_v = rv;
    if (r) begin
      exp1_d = rdat;
      exp1_v = rv;
    end
    if (w) begin
      mem_m[a] = d;
      wr_m[a]  = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rd1 !== '0 || rdv1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat1: rd=%h rd_valid=%b expected 0/0", rd1, rdv1);
    end
    checks++;
    if (rd2 !== '0 || rdv2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat2: rd=%h rd_valid=%b expected 0/0", rd2, rdv2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 4'd5);
    checks++;
    if (rdv1 !== 1'b0) begin
      errors++;
      $display("FAIL unwritten_read_lat1: rd_valid=%b expected 0", rdv1);
    end
    idle();
    checks++;
    if (rdv2 !== 1'b0) begin
      errors++;
      $display("FAIL unwritten_read_lat2: rd_valid=%b expected 0", rdv2);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    step(1'b1, 4'd3, 36'hABC, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 4'd3);
    checks++;
    if (rd1 !== 36'hABC || rdv1 !== 1'b1) begin
      errors++;
      $display("FAIL write_read_lat1: rd=%h rd_valid=%b expected abc/1", rd1, rdv1);
    end
    checks++;
    if (rdv2 !== 1'b0) begin
      errors++;
      $display("FAIL write_read_lat2_early: rd_valid=%b expected 0", rdv2);
    end
    idle();
    checks++;
    if (rd2 !== 36'hABC || rdv2 !== 1'b1) begin
      errors++;
      $display("FAIL write_read_lat2: rd=%h rd_valid=%b expected abc/1", rd2, rdv2);
    end
    $display("test_write_read done");
  endtask

  task automatic test_rdw_same_addr();
    logic [DW-1:0] want;
    want = WF ? 36'h22 : 36'h11;
    step(1'b1, 4'd7, 36'h11, 1'b0, '0);
    step(1'b1, 4'd7, 36'h22, 1'b1, 4'd7);
    checks++;
    if (rd1 !== want || rdv1 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_lat1: rd=%h rd_valid=%b expected %h/1", rd1, rdv1, want);
    end
    idle();
    checks++;
    if (rd2 !== want || rdv2 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_lat2: rd=%h rd_valid=%b expected %h/1", rd2, rdv2, want);
    end
    $display("test_rdw_same_addr done (write_first=%0d)", WF);
  endtask

  task automatic test_boundary();
    logic [AW-1:0] top_addr;
    top_addr = '1;
    step(1'b1, '0, 36'h0_1234_5678, 1'b0, '0);
    step(1'b1, top_addr, 36'hF_EDCB_A987, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, '0);
    checks++;
    if (rd1 !== 36'h0_1234_5678 || rdv1 !== 1'b1) begin
      errors++;
      $display("FAIL boundary_lo_lat1: rd=%h rd_valid=%b expected 012345678/1", rd1, rdv1);
    end
    step(1'b0, '0, '0, 1'b1, top_addr);
    checks++;
    if (rd1 !== 36'hF_EDCB_A987 || rdv1 !== 1'b1) begin
      errors++;
      $display("FAIL boundary_hi_lat1: rd=%h rd_valid=%b expected fedcba987/1", rd1, rdv1);
    end
    checks++;
    if (rd2 !== 36'h0_1234_5678 || rdv2 !== 1'b1) begin
      errors++;
      $display("FAIL boundary_lo_lat2: rd=%h rd_valid=%b expected 012345678/1", rd2, rdv2);
    end
    idle();
    checks++;
    if (rd2 !== 36'hF_EDCB_A987 || rdv2 !== 1'b1) begin
      errors++;
      $display("FAIL boundary_hi_lat2: rd=%h rd_valid=%b expected fedcba987/1", rd2, rdv2);
    end
    $display("test_boundary done");
  endtask

  task automatic test_hold();
    step(1'b0, '0, '0, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0, AW'($urandom_range(0, DEPTH - 1)));
      checks++;
      if (rd1 !== 36'hABC || rdv1 !== 1'b1) begin
        errors++;
        $display("FAIL hold_lat1[%0d]: rd=%h rd_valid=%b expected abc/1", i, rd1, rdv1);
      end
      checks++;
      if (rd2 !== 36'hABC || rdv2 !== 1'b1) begin
        errors++;
        $display("FAIL hold_lat2[%0d]: rd=%h rd_valid=%b expected abc/1", i, rd2, rdv2);
      end
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 4'd4, 36'h4_4444_4444, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 4'd4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd1 !== '0 || rdv1 !== 1'b0 || rd2 !== '0 || rdv2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flush: rd1=%h v1=%b rd2=%h v2=%b expected all 0",
               rd1, rdv1, rd2, rdv2);
    end
    @(negedge clk);
    we = 1'b1; wa = 4'd9; wd = 36'h9; re = 1'b0;
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 4'd4);
    checks++;
    if (rdv1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_addr4_lat1: rd_valid=%b expected 0", rdv1);
    end
    step(1'b0, '0, '0, 1'b1, 4'd9);
    checks++;
    if (rdv2 !== 1'b0 || rdv1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_dropped_write: v1=%b v2=%b expected 0/0", rdv1, rdv2);
    end
    step(1'b1, 4'd4, 36'h5_5555_5555, 1'b0, '0);
    step(1'b0, '0, '0, 1'b1, 4'd4);
    checks++;
    if (rd1 !== 36'h5_5555_5555 || rdv1 !== 1'b1) begin
      errors++;
      $display("FAIL rewrite_addr4_lat1: rd=%h rd_valid=%b expected 555555555/1", rd1, rdv1);
    end
    idle();
    checks++;
    if (rd2 !== 36'h5_5555_5555 || rdv2 !== 1'b1) begin
      errors++;
      $display("FAIL rewrite_addr4_lat2: rd=%h rd_valid=%b expected 555555555/1", rd2, rdv2);
    end
    $display("test_reset_mid_read done");
  endtask

  task automatic test_random();
    logic [63:0] rnd;
    bit          w, r;
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom()};
      w = ($urandom_range(0, 99) < 50);
      r = ($urandom_range(0, 99) < 60);
      step(w, AW'($urandom_range(0, DEPTH - 1)), rnd[DW-1:0],
           r, AW'($urandom_range(0, DEPTH - 1)));
      checks++;
      if (rdv1 !== exp1_v || (exp1_v && rd1 !== exp1_d)) begin
        errors++;
        $display("FAIL random_lat1[%0d]: rd=%h v=%b expected %h/%b", i, rd1, rdv1, exp1_d, exp1_v);
      end
      checks++;
      if (rdv2 !== exp2_v || (exp2_v && rd2 !== exp2_d)) begin
        errors++;
        $display("FAIL random_lat2[%0d]: rd=%h v=%b expected %h/%b", i, rd2, rdv2, exp2_d, exp2_v);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_rdw_same_addr();
    test_boundary();
    test_hold();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
